inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter PC_WIDTH, 32, fetch address width.
REQ-002 SHALL have parameter INST_WIDTH, 32, instruction width.
REQ-003 SHALL have parameter INST_NOP, 32'h00000013, bubble encoding (addi x0,x0,0).
REQ-004 SHALL have parameter DEPTH, 2, combined outstanding-plus-buffered fetch credit.
REQ-005 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port: i_pc  in  PC_WIDTH  current PC from PC register.
REQ-008 SHALL have port: i_stall  in  1  IF-stage bit of pipeline stall vector.
REQ-009 SHALL have port: i_flush  in  1  IF-stage bit of pipeline flush vector.
REQ-010 SHALL have ports: o_ibus_req out 1, o_ibus_addr out PC_WIDTH, i_ibus_gnt in 1  instruction-bus request channel.
REQ-011 SHALL have ports: i_ibus_rvalid in 1, i_ibus_rdata in INST_WIDTH, i_ibus_err in 1  in-order response channel.
REQ-012 SHALL have ports: o_inst_valid out 1, o_inst out INST_WIDTH, o_inst_pc out PC_WIDTH, o_inst_err out 1  IF/ID outputs.
REQ-013 SHALL have port: o_fetch_stall  out  1  holds PC register when no fetch was accepted this cycle.

Function
REQ-014 SHALL drive o_ibus_addr = i_pc and o_ibus_req = ~i_stall & ~i_flush & (outstanding + buffered < DEPTH).
REQ-015 SHALL treat a request as accepted in a cycle with o_ibus_req & i_ibus_gnt; accepted PC pushed to address queue same edge.
REQ-016 SHALL drive o_fetch_stall = ~i_flush & ~(o_ibus_req & i_ibus_gnt), combinationally.
REQ-017 SHALL pair each i_ibus_rvalid with oldest queued PC, storing {pc, rdata, err} in a DEPTH-entry response FIFO.
REQ-018 SHALL bypass FIFO when empty: rvalid in cycle N -> o_inst_valid=1 with that data at edge ending N (visible N+1), if ~i_stall.
REQ-019 SHALL, each non-stalled cycle, load outputs from FIFO head (or bypass) with o_inst_valid=1, else o_inst_valid=0, o_inst=INST_NOP.
REQ-020 SHALL hold all IF/ID outputs unchanged and pop nothing while i_stall=1 (and i_flush=0); responses still enqueue.
REQ-021 SHALL on response with i_ibus_err=1 output o_inst=INST_NOP, o_inst_err=1, o_inst_pc=faulting PC.
REQ-022 SHALL on i_flush: clear FIFO and address queue, set drop counter = outstanding count, next outputs valid=0/NOP; flush overrides stall.
REQ-023 SHALL discard responses while drop counter > 0, decrementing per rvalid; rvalid coincident with i_flush is counted as dropped.
REQ-024 SHALL support simultaneous accept, response and pop in one cycle without loss or duplication.
REQ-025 SHALL never exceed DEPTH; response arriving with FIFO full is impossible by credit rule (assertion).
REQ-026 SHALL keep counters 0..DEPTH, no wrap; FIFO pointers wrap modulo DEPTH.

Reset
REQ-027 SHALL on rst: o_inst_valid=0, o_inst=INST_NOP, o_inst_pc=0, o_inst_err=0, FIFO/queue empty, outstanding=0, drop=0.
REQ-028 SHALL keep o_ibus_req=0 during rst; responses during/after rst for pre-reset requests are not expected (bus reset together).
REQ-029 SHALL give rst priority over i_flush and i_stall.

Structure
REQ-030 SHALL take INST_NOP, PC_WIDTH, stall/flush vector indices from shared defines.vh.
REQ-031 SHALL instantiate one sub-module fetch_fifo (parametric depth/width, push/pop/full/empty, clear) for response FIFO and address queue.

Verification
REQ-032 Reset then gnt=1, rvalid 1 cycle after grant, i_pc 0,4,8 -> o_inst_valid from 3rd cycle, o_inst_pc 0,4,8 back-to-back, o_fetch_stall=0.
REQ-033 i_stall=1 for 3 cycles with 2 responses arriving -> outputs frozen, o_ibus_req=0 once credits=0, both instructions emerge in order after release.
REQ-034 Two outstanding, i_flush 1 cycle, responses arrive next 2 cycles -> both dropped, o_inst_valid=0, first fetch of new PC 0x100 emitted.
REQ-035 gnt=0 for 4 cycles -> o_fetch_stall=1 for 4 cycles, o_ibus_addr stable, no output.
REQ-036 rvalid with i_ibus_err=1 at PC 0x20 -> o_inst=0x00000013, o_inst_err=1, o_inst_pc=0x20.
REQ-037 rst asserted with 2 in flight and FIFO full -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants: default widths, bubble encoding, stall/flush vector bit indices.
// Also provides the counter-width helper used by the fetch datapath and its FIFOs.
package inst_fetch_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 32;
  localparam int unsigned INST_WIDTH_DEF  = 32;
  localparam logic [31:0] INST_NOP_DEF    = 32'h0000_0013;
  localparam int unsigned FETCH_DEPTH_DEF = 2;

  // IF-stage positions within the pipeline-wide stall and flush vectors
  localparam int unsigned STALL_IDX_IF = 0;
  localparam int unsigned FLUSH_IDX_IF = 0;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; read data is the head entry, visible combinationally.
// Zero-latency read; a push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: issues credit-limited instruction-bus fetches, pairs in-order responses with their PCs.
// Response to IF/ID in one cycle via bypass or FIFO; stall freezes outputs, flush drops in-flight responses.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned           PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned           INST_WIDTH = INST_WIDTH_DEF,
  parameter logic [INST_WIDTH-1:0] INST_NOP   = INST_NOP_DEF,
  parameter int unsigned           DEPTH      = FETCH_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic                  o_ibus_req,
  output logic [PC_WIDTH-1:0]   o_ibus_addr,
  input  logic                  i_ibus_gnt,
  input  logic                  i_ibus_rvalid,
  input  logic [INST_WIDTH-1:0] i_ibus_rdata,
  input  logic                  i_ibus_err,
  output logic                  o_inst_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_inst_pc,
  output logic                  o_inst_err,
  output logic                  o_fetch_stall
);

  localparam int unsigned CW = cnt_width(DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  err;
  } rsp_ent_t;

  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       drop_cnt;
  logic [CW-1:0]       q_count;
  logic [CW-1:0]       rsp_count;
  logic                q_full, q_empty, rsp_full, rsp_empty;
  logic [PC_WIDTH-1:0] q_head;
  rsp_ent_t            rsp_in, rsp_head, load_ent;
  logic                credit_ok, accept, rsp_drop, rsp_keep;
  logic                bypass, rsp_push, rsp_pop, load_vld;

  // Bus requests in flight plus buffered responses share the DEPTH credit pool
  assign credit_ok     = (32'(outstanding) + 32'(rsp_count)) < DEPTH;
  assign o_ibus_req    = ~rst & ~i_stall & ~i_flush & credit_ok;
  assign o_ibus_addr   = i_pc;
  assign accept        = o_ibus_req & i_ibus_gnt;
  assign o_fetch_stall = ~i_flush & ~accept;

  assign rsp_drop = i_ibus_rvalid & (i_flush | (drop_cnt != '0));
  assign rsp_keep = i_ibus_rvalid & ~rsp_drop;
  assign bypass   = rsp_keep & rsp_empty & ~i_stall;
  assign rsp_push = rsp_keep & ~bypass;
  assign rsp_pop  = ~i_stall & ~i_flush & ~rsp_empty;

  assign rsp_in.pc   = q_head;
  assign rsp_in.inst = i_ibus_rdata;
  assign rsp_in.err  = i_ibus_err;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(PC_WIDTH)) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (i_flush),
    .push      (accept),
    .push_data (i_pc),
    .pop       (rsp_keep),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(rsp_ent_t))) u_rsp_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (i_flush),
    .push      (rsp_push),
    .push_data (rsp_in),
    .pop       (rsp_pop),
    .pop_data  (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  always_comb begin
    load_vld = 1'b0;
    load_ent = rsp_head;
    if (!rsp_empty) begin
      load_vld = 1'b1;
    end else if (rsp_keep) begin
      load_vld = 1'b1;
      load_ent = rsp_in;
    end
  end

  // Outstanding counts every bus request still owed a response, including ones to be dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(i_ibus_rvalid);
      if (i_flush)       drop_cnt <= outstanding - CW'(i_ibus_rvalid);
      else if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_inst_valid <= 1'b0;
      o_inst       <= INST_NOP;
      o_inst_pc    <= '0;
      o_inst_err   <= 1'b0;
    end else if (i_flush) begin
      o_inst_valid <= 1'b0;
      o_inst       <= INST_NOP;
      o_inst_err   <= 1'b0;
    end else if (!i_stall) begin
      if (load_vld) begin
        o_inst_valid <= 1'b1;
        o_inst       <= load_ent.err ? INST_NOP : load_ent.inst;
        o_inst_pc    <= load_ent.pc;
        o_inst_err   <= load_ent.err;
      end else begin
        o_inst_valid <= 1'b0;
        o_inst       <= INST_NOP;
        o_inst_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_ibus_rvalid && outstanding == '0));
      assert (!(rsp_push && rsp_full && !rsp_pop));
      assert (!(accept && q_full));
      assert (!(rsp_keep && q_empty));
      assert ((32'(q_count) + 32'(drop_cnt)) == 32'(outstanding));
    end
  end

endmodule
